rx_symbol_aligner: RTL and testbench

//  Receive-side serial-to-parallel stage directly upstream of the symbol demux.

---
 rtl/rx_symbol_aligner_if.sv | 9 +
 rtl/rx_symbol_aligner.sv | 89 ++++++++
 tb/tb_rx_symbol_aligner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rx_symbol_aligner_if.sv
// rx_symbol_aligner_if: serial input and aligned-symbol outputs of the aligner
interface rx_symbol_aligner_if;
  logic       SERIAL_IN;
  logic [7:0] Rx_buffer;
  logic       VALID;
  logic       ALIGNED;
  modport master (output SERIAL_IN, input Rx_buffer, VALID, ALIGNED);
  modport slave (input SERIAL_IN, output Rx_buffer, VALID, ALIGNED);
endinterface

// File: rtl/rx_symbol_aligner.sv
// rx_symbol_aligner: serial-to-parallel stage that locks onto COM symbols and forwards aligned bytes
module rx_symbol_aligner #(
  parameter logic [7:0] COM_SYM        = 8'hBC,
  parameter int         LOCK_COUNT     = 4,
  parameter int         MISALIGN_LIMIT = 2
) (
  input logic CLK,
  input logic RESET_L,
  rx_symbol_aligner_if.slave bus
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISALIGN_LIMIT + 1);
  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;
  state_t        state, state_n;
  logic [7:0]    sr, win, rx_buf, rx_buf_n;
  logic [3:0]    fill_cnt, fill_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [CW-1:0] com_cnt, com_n, com_inc;
  logic [MW-1:0] miss_cnt, miss_n, miss_inc;
  logic          valid, valid_n, hit, bnd;
  assign bus.Rx_buffer = rx_buf;
  assign bus.VALID     = valid;
  assign bus.ALIGNED   = (state == LOCKED);
  // next-state: window compare, boundary tracking, lock/unlock decisions and byte forwarding
  always_comb begin
    win      = {bus.SERIAL_IN, sr[7:1]};
    hit      = (fill_cnt >= 4'd7) && (win == COM_SYM);
    bnd      = (bit_cnt == 3'd7);
    fill_n   = (fill_cnt == 4'd8) ? fill_cnt : fill_cnt + 4'd1;
    com_inc  = (com_cnt == CW'(LOCK_COUNT)) ? com_cnt : com_cnt + CW'(1);
    miss_inc = (miss_cnt == MW'(MISALIGN_LIMIT)) ? miss_cnt : miss_cnt + MW'(1);
    state_n  = state;
    bit_n    = bit_cnt + 3'd1;
    com_n    = com_cnt;
    miss_n   = miss_cnt;
    rx_buf_n = rx_buf;
    valid_n  = 1'b0;
    case (state)
      HUNT: if (hit) begin
        bit_n   = 3'd0;
        com_n   = CW'(1);
        miss_n  = '0;
        state_n = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
      end
      ALIGN: if (hit && bnd) begin
        com_n = com_inc;
        if (com_inc == CW'(LOCK_COUNT)) begin
          state_n = LOCKED;
          miss_n  = '0;
        end
      end else if (hit) begin
        bit_n = 3'd0;
        com_n = CW'(1);
      end
      LOCKED: if (hit && bnd) begin
        miss_n = '0;
      end else if (hit) begin
        miss_n  = miss_inc;
        state_n = (miss_inc == MW'(MISALIGN_LIMIT)) ? HUNT : LOCKED;
      end else if (bnd) begin
        rx_buf_n = win;
        valid_n  = 1'b1;
      end
      default: state_n = HUNT;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= HUNT;
      sr       <= '0;
      fill_cnt <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      miss_cnt <= '0;
      rx_buf   <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= win;
      fill_cnt <= fill_n;
      bit_cnt  <= bit_n;
      com_cnt  <= com_n;
      miss_cnt <= miss_n;
      rx_buf   <= rx_buf_n;
      valid    <= valid_n;
    end
  end
endmodule

// File: tb/tb_rx_symbol_aligner.sv
// tb_rx_symbol_aligner: table vectors, corner sequences and random stream against a reference model
module tb_rx_symbol_aligner;
  logic CLK = 1'b0;
  logic RESET_L = 1'b0;
  rx_symbol_aligner_if bus();
  rx_symbol_aligner dut (.CLK(CLK), .RESET_L(RESET_L), .bus(bus));
  always #5 CLK = ~CLK;
  int nvec = 0;
  int nmis = 0;
  int m_mode;
  longint m_n, m_anchor;
  int m_fill, m_cnt, m_miss;
  logic [7:0] m_win, m_buf;
  logic m_valid;
  int n_valid;
  logic [7:0] got[$];
  typedef struct {
    string           name;
    int              pre;
    int              ncom;
    int              nd;
    logic [2:0][7:0] d;
    logic            exp_al;
    int              exp_nv;
  } vec_t;
  vec_t vt[5];
  function automatic vec_t mk(string name, int pre, int ncom, int nd, logic [7:0] d0, logic [7:0] d1,
                              logic [7:0] d2, logic exp_al, int exp_nv);
    vec_t v;
    v.name = name; v.pre = pre; v.ncom = ncom; v.nd = nd;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.exp_al = exp_al; v.exp_nv = exp_nv;
    return v;
  endfunction
  // reference model: boundary = whole number of bytes after the anchoring COM
  function void model_reset();
    m_mode = 0; m_n = 0; m_anchor = 0; m_fill = 0; m_cnt = 0; m_miss = 0;
    m_win = 8'h00; m_buf = 8'h00; m_valid = 1'b0;
  endfunction
  function void model_step(logic b);
    logic hit, bnd;
    m_n++;
    m_win = {b, m_win[7:1]};
    if (m_fill < 8) m_fill++;
    hit = (m_fill == 8) && (m_win == 8'hBC);
    bnd = ((m_n - m_anchor) % 8) == 0;
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (hit) begin m_anchor = m_n; m_cnt = 1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (hit && bnd) begin
        m_cnt++;
        if (m_cnt == 4) begin m_mode = 2; m_miss = 0; end
      end else if (hit) begin
        m_anchor = m_n; m_cnt = 1;
      end
    end else begin
      if (hit && bnd) m_miss = 0;
      else if (hit) begin
        m_miss++;
        if (m_miss == 2) m_mode = 0;
      end else if (bnd) begin
        m_buf = m_win; m_valid = 1'b1;
      end
    end
  endfunction
  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_bit(logic b);
    bus.SERIAL_IN = b;
    @(posedge CLK);
    #1;
    model_step(b);
    check("cycle", {bus.ALIGNED, bus.VALID, bus.Rx_buffer}, {m_mode == 2, m_valid, m_buf});
    if (bus.VALID === 1'b1) begin
      n_valid++;
      got.push_back(bus.Rx_buffer);
    end
  endtask
  task automatic send_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask
  task automatic do_reset(string name);
    RESET_L = 1'b0;
    #1;
    check(name, {bus.ALIGNED, bus.VALID, bus.Rx_buffer}, 10'h000);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    n_valid = 0;
    got.delete();
  endtask
  initial begin
    logic [7:0] g;
    int nv0;
    g = 8'b0000_1101;
    bus.SERIAL_IN = 1'b0;
    vt[0] = mk("t1_lock",   0, 4, 2, 8'h5A, 8'h3C, 8'h00, 1'b1, 2);
    vt[1] = mk("t2_offset", 3, 4, 1, 8'hA5, 8'h00, 8'h00, 1'b1, 1);
    vt[2] = mk("t3_short",  0, 3, 2, 8'h11, 8'h22, 8'h00, 1'b0, 0);
    vt[3] = mk("t6_ctrl",   0, 4, 3, 8'hFB, 8'h01, 8'hFD, 1'b1, 3);
    vt[4] = mk("t_off5",    5, 4, 1, 8'h3C, 8'h00, 8'h00, 1'b1, 1);
    @(posedge CLK);
    #1;
    for (int v = 0; v < 5; v++) begin
      do_reset({vt[v].name, "_reset"});
      for (int i = 0; i < vt[v].pre; i++) send_bit(g[i]);
      for (int i = 0; i < vt[v].ncom; i++) send_byte(8'hBC);
      for (int i = 0; i < vt[v].nd; i++) send_byte(vt[v].d[i]);
      check({vt[v].name, "_aligned"}, 10'(bus.ALIGNED), 10'(vt[v].exp_al));
      check({vt[v].name, "_nvalid"}, 10'(n_valid), 10'(vt[v].exp_nv));
      for (int k = 0; k < vt[v].exp_nv; k++)
        check({vt[v].name, "_data"}, (got.size() > k) ? 10'(got[k]) : 10'h3FF, 10'(vt[v].d[k]));
      check({vt[v].name, "_hold"}, 10'(bus.Rx_buffer), vt[v].exp_nv > 0 ? 10'(vt[v].d[vt[v].nd - 1]) : 10'h000);
    end
    do_reset("t4_reset");
    repeat (4) send_byte(8'hBC);
    send_byte(8'h5A);
    repeat (3) send_bit(1'b0);
    send_byte(8'hBC);
    check("t4_first_miss", 10'(bus.ALIGNED), 10'h001);
    nv0 = n_valid;
    send_byte(8'h00);
    send_byte(8'hBC);
    check("t4_drop", 10'(bus.ALIGNED), 10'h000);
    check("t4_between", 10'(n_valid - nv0), 10'd2);
    repeat (3) send_byte(8'hBC);
    send_byte(8'h77);
    do_reset("t5_first_reset");
    repeat (4) send_byte(8'hBC);
    send_byte(8'h5A);
    repeat (3) send_bit(1'b1);
    check("t5_locked", 10'(bus.ALIGNED), 10'h001);
    do_reset("t5_mid_reset");
    repeat (3) send_byte(8'hBC);
    send_byte(8'h5A);
    check("t5_no_lock", 10'(bus.ALIGNED), 10'h000);
    check("t5_no_valid", 10'(n_valid), 10'h000);
    send_byte(8'hBC);
    send_byte(8'h5A);
    check("t5_relock", 10'(bus.ALIGNED), 10'h001);
    check("t5_valid", 10'(n_valid), 10'h001);
    do_reset("rand_reset");
    for (int s = 0; s < 400; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) send_byte(8'hBC);
      else if (r == 4) repeat ($urandom_range(1, 7)) send_bit(1'($urandom));
      else send_byte(8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
